// File: rtl/pipe_scroller.sv
// Scrolling pipe-obstacle generator for the 8x8 LED game field.
// Optional macro PIPE_SCROLLER_SCORE_BCD_EN switches the score to two BCD digits.
module pipe_scroller #(
  parameter int SCROLL_DIV = 1024,
  parameter int GAP        = 3,
  parameter int SPACING    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [3:0]  rnd_in,
  input  logic        rnd_valid,
  output logic        rnd_ack,
  output logic [63:0] grid,
  output logic [7:0]  bird_col,
  output logic [7:0]  score,
  output logic        running
);

  localparam int DW = $clog2(SCROLL_DIV);
  localparam int SW = $clog2(SPACING);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCROLL_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPACING - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic          clear;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] spawn_cnt;
  logic          step, spawn_due, take;
  logic [3:0]    gap_top;
  logic [7:0]    pipe_col, new_col;
  logic [63:0]   shifted;
  logic [7:0]    score_inc;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE:    if (start) begin state_d = RUN; clear = 1'b1; end
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (start) begin state_d = RUN; clear = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  assign step      = (state_q == RUN) && !halt && (div_cnt == DIV_LAST);
  assign spawn_due = (spawn_cnt == SPAWN_LAST);
  assign take      = step && spawn_due && rnd_valid;
  // The consume strobe is combinational so the LFSR can advance on the same edge.
  assign rnd_ack   = take && reset;

  always_comb begin
    if ({1'b0, rnd_in[2:0]} <= 4'(8 - GAP)) gap_top = {1'b0, rnd_in[2:0]};
    else                                   gap_top = {1'b0, rnd_in[2:0]} - 4'(9 - GAP);
  end

  assign new_col = take ? pipe_col : 8'h00;

  for (genvar r = 0; r < 8; r++) begin : g_row
    assign pipe_col[r] = !((4'(r) >= gap_top) && (4'(r) < gap_top + 4'(GAP)));
    assign bird_col[r] = grid[8*r+1];
    for (genvar c = 0; c < 8; c++) begin : g_col
      if (c < 7) begin : g_shift
        assign shifted[8*r+c] = grid[8*r+c+1];
      end else begin : g_edge
        assign shifted[8*r+c] = new_col[r];
      end
    end
  end

`ifdef PIPE_SCROLLER_SCORE_BCD_EN
  always_comb begin
    score_inc = score;
    if (score != 8'h99) begin
      if (score[3:0] == 4'd9) score_inc = {score[7:4] + 4'd1, 4'd0};
      else                    score_inc = {score[7:4], score[3:0] + 4'd1};
    end
  end
`else
  assign score_inc = (score == 8'hFF) ? score : score + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_cnt   <= '0;
      spawn_cnt <= SPAWN_LAST;
      grid      <= '0;
      score     <= '0;
      running   <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      if (clear) begin
        div_cnt   <= '0;
        spawn_cnt <= SPAWN_LAST;
        grid      <= '0;
        score     <= '0;
      end else if (state_q == RUN && !halt) begin
        if (step) begin
          div_cnt <= '0;
          grid    <= shifted;
          if (bird_col != 8'h00) score <= score_inc;
          // A due spawn without random data holds so the next step retries.
          if (spawn_due) begin
            if (rnd_valid) spawn_cnt <= '0;
          end else begin
            spawn_cnt <= spawn_cnt + SW'(1);
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against a column-array reference model.
module tb_pipe_scroller;
  localparam int SCROLL_DIV = 4;
  localparam int GAP        = 3;
  localparam int SPACING    = 4;

  logic        clk = 0;
  logic        reset, start, halt, rnd_valid;
  logic [3:0]  rnd_in;
  logic        rnd_ack, running;
  logic [63:0] grid;
  logic [7:0]  bird_col, score;

  int checks = 0;
  int failures = 0;

  logic [7:0] mcol [8];
  int         mspawn;
  int         mscore;

  pipe_scroller #(.SCROLL_DIV(SCROLL_DIV), .GAP(GAP), .SPACING(SPACING)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
    .grid(grid), .bird_col(bird_col), .score(score), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pipe_of(input logic [3:0] v);
    int r = int'(v[2:0]);
    int top = (r <= 8 - GAP) ? r : r - (9 - GAP);
    logic [7:0] col = 8'hFF;
    for (int i = 0; i < GAP; i++) col[top+i] = 1'b0;
    return col;
  endfunction

  function automatic logic [63:0] model_grid();
    logic [63:0] g = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[8*r+c] = mcol[c][r];
    return g;
  endfunction

  function automatic logic [7:0] dut_col(input int c);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = grid[8*r+c];
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 8; c++) mcol[c] = 8'h00;
    mspawn = SPACING - 1;
    mscore = 0;
  endtask

  // Entered at the negedge right after a step (or start) edge; leaves at the negedge after the next step.
  task automatic run_step(input logic v, input logic [3:0] r);
    logic exp_ack;
    logic [7:0] newc;
    rnd_valid = v;
    rnd_in    = r;
    for (int k = 0; k < SCROLL_DIV; k++) begin
      #1;
      exp_ack = (k == SCROLL_DIV - 1) && (mspawn == SPACING - 1) && v;
      checks++;
      if (rnd_ack !== exp_ack) begin
        failures++;
        $display("FAIL ack k=%0d got=%b exp=%b", k, rnd_ack, exp_ack);
      end
      @(negedge clk);
    end
    newc = 8'h00;
    if (mspawn == SPACING - 1 && v) newc = pipe_of(r);
    if (mcol[1] != 8'h00 && mscore < 255) mscore++;
    for (int c = 0; c < 7; c++) mcol[c] = mcol[c+1];
    mcol[7] = newc;
    if (mspawn == SPACING - 1) mspawn = v ? 0 : mspawn;
    else mspawn++;
    checks++;
    if (grid !== model_grid()) begin
      failures++;
      $display("FAIL step_grid got=%h exp=%h", grid, model_grid());
    end
    checks++;
    if (score !== 8'(mscore)) begin
      failures++;
      $display("FAIL step_score got=%0d exp=%0d", score, mscore);
    end
    checks++;
    if (bird_col !== mcol[1]) begin
      failures++;
      $display("FAIL step_bird got=%h exp=%h", bird_col, mcol[1]);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 0; start = 1; halt = 0; rnd_valid = 0; rnd_in = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (grid !== 64'h0 || score !== 8'h0 || running !== 1'b0 || rnd_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs grid=%h score=%h running=%b ack=%b exp all 0", grid, score, running, rnd_ack);
    end
    reset = 1; start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0 || grid !== 64'h0) begin
      failures++;
      $display("FAIL reset_idle running=%b grid=%h exp 0", running, grid);
    end
    do_start();
    #1;
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL start_running got=%b exp=1", running);
    end
  endtask

  task automatic test_first_pipe();
    run_step(1'b1, 4'b0010);
    checks++;
    if (dut_col(7) !== 8'hE3) begin
      failures++;
      $display("FAIL first_pipe col7=%h exp=e3", dut_col(7));
    end
    for (int i = 0; i < 3; i++) begin
      run_step(1'b1, 4'($urandom));
      checks++;
      if (dut_col(7) !== 8'h00) begin
        failures++;
        $display("FAIL empty_col i=%0d col7=%h exp=00", i, dut_col(7));
      end
    end
  endtask

  task automatic test_bit3();
    run_step(1'b1, 4'b1111);
    checks++;
    if (dut_col(7) !== 8'hF1) begin
      failures++;
      $display("FAIL bit3_ignored col7=%h exp=f1", dut_col(7));
    end
  endtask

  task automatic test_retry();
    logic [3:0] r;
    for (int i = 0; i < 3; i++) run_step(1'b1, 4'($urandom));
    run_step(1'b0, 4'($urandom));
    checks++;
    if (dut_col(7) !== 8'h00) begin
      failures++;
      $display("FAIL retry_empty col7=%h exp=00", dut_col(7));
    end
    r = 4'($urandom);
    run_step(1'b1, r);
    checks++;
    if (dut_col(7) !== pipe_of(r)) begin
      failures++;
      $display("FAIL retry_pipe col7=%h exp=%h", dut_col(7), pipe_of(r));
    end
    for (int i = 0; i < 4; i++) run_step(1'b1, 4'($urandom));
    checks++;
    if (dut_col(7) === 8'h00) begin
      failures++;
      $display("FAIL retry_next_pipe col7=%h exp=nonzero", dut_col(7));
    end
  endtask

  task automatic test_score();
    logic [3:0] r1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    do_start();
    r1 = 4'($urandom);
    run_step(1'b1, r1);
    for (int i = 2; i <= 7; i++) run_step(1'b1, 4'($urandom));
    checks++;
    if (bird_col !== pipe_of(r1) || score !== 8'd0) begin
      failures++;
      $display("FAIL pipe_at_bird bird=%h score=%0d exp bird=%h score=0", bird_col, score, pipe_of(r1));
    end
    run_step(1'b1, 4'($urandom));
    checks++;
    if (score !== 8'd1) begin
      failures++;
      $display("FAIL first_pass score=%0d exp=1", score);
    end
    for (int i = 0; i < 1400; i++) run_step(($urandom % 8) != 0, 4'($urandom));
    checks++;
    if (score !== 8'hFF) begin
      failures++;
      $display("FAIL score_saturate score=%0d exp=255", score);
    end
  endtask

  task automatic test_halt();
    logic [63:0] frozen;
    @(negedge clk);
    halt = 1; start = 1;
    @(negedge clk);
    halt = 0; start = 0;
    frozen = model_grid();
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (grid !== frozen || score !== 8'(mscore) || running !== 1'b0 || rnd_ack !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold i=%0d grid=%h score=%0d running=%b exp grid=%h score=%0d running=0",
                 i, grid, score, running, frozen, mscore);
      end
      @(negedge clk);
    end
    do_start();
    #1;
    checks++;
    if (grid !== 64'h0 || score !== 8'h0 || running !== 1'b1) begin
      failures++;
      $display("FAIL restart grid=%h score=%0d running=%b exp 0,0,1", grid, score, running);
    end
    for (int i = 0; i < 6; i++) run_step(1'b1, 4'($urandom));
  endtask

  task automatic test_reset_mid();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    #1;
    checks++;
    if (grid !== 64'h0 || score !== 8'h0 || running !== 1'b0 || rnd_ack !== 1'b0 || bird_col !== 8'h0) begin
      failures++;
      $display("FAIL reset_mid grid=%h score=%0d running=%b ack=%b bird=%h exp all 0",
               grid, score, running, rnd_ack, bird_col);
    end
    reset = 1;
    do_start();
    run_step(1'b1, 4'($urandom));
    run_step(1'b1, 4'($urandom));
  endtask

  initial begin
    test_reset();
    test_first_pipe();
    test_bit3();
    test_retry();
    test_score();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
